multicycle_control: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath. It sits directly upstream of the ALU operation decoder and drives its ALUOp[1:0] and i_op[2:0] inputs. It also drives every datapath mux select and write enable, one step per instruction phase. Memory phases stall on a ready handshake.

---
 rtl/multicycle_control_pkg.sv | 32 +++
 rtl/multicycle_ctrl_out_dec.sv | 107 ++++++++++
 rtl/multicycle_control.sv | 91 +++++++++
 tb/tb_multicycle_control.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcode constants, control-field encodings and FSM state enum shared by the control FSM and its output decoder
package multicycle_control_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IOP   = 2'b11;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_ADDR, S_MEM_RD, S_WB_LD, S_MEM_WR, S_EX_R,
    S_WB_R, S_EX_I, S_WB_I, S_BEQ, S_BNE, S_JMP
  } state_t;
  function automatic logic is_zero_ext(input logic [5:0] op);
    return op inside {OP_ANDI, OP_ORI, OP_XORI};
  endfunction
endpackage

// File: rtl/multicycle_ctrl_out_dec.sv
// multicycle_ctrl_out_dec: combinational map of state, latched opcode and mem_ready to every datapath control; quiet forces all strobes and write enables low
module multicycle_ctrl_out_dec
  import multicycle_control_pkg::*;
(
  input  logic       clk_unused_n,
  input  state_t     state,
  input  logic [5:0] opcode_reg,
  input  logic       ready,
  input  logic       quiet,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       zero_ext,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic [2:0] i_op
);
  logic unused;
  assign unused = clk_unused_n;
  assign i_op = opcode_reg[2:0];
  always_comb begin
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne = 1'b0;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_B;
    zero_ext = 1'b0;
    pc_source = PCSRC_ALU;
    alu_op = ALUOP_ADD;
    case (state)
      S_IF: begin
        mem_read = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write = ready;
        pc_write = ready;
      end
      S_ID: alu_src_b = SRCB_IMM_SH;
      S_EX_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d = 1'b1;
      end
      S_WB_LD: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d = 1'b1;
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op = ALUOP_FUNCT;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
      end
      S_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op = ALUOP_IOP;
        zero_ext = is_zero_ext(opcode_reg);
      end
      S_WB_I: reg_write = 1'b1;
      S_BEQ, S_BNE: begin
        alu_src_a = 1'b1;
        alu_op = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source = PCSRC_ALUOUT;
        branch_ne = state == S_BNE;
      end
      S_JMP: begin
        pc_write = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
    if (quiet) begin
      pc_write = 1'b0;
      pc_write_cond = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      ir_write = 1'b0;
      reg_write = 1'b0;
    end
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM (in: clk, rst, opcode, mem_ready; out: PC/memory/IR/regfile strobes, mux selects, alu_op, i_op, illegal)
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       zero_ext,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic [2:0] i_op,
  output logic       illegal
);
  logic [STATE_W-1:0] state_q;
  logic [5:0] opcode_reg;
  state_t state, state_d;
  logic ready, bad;
  assign ready = USE_MEM_READY ? mem_ready : 1'b1;
  assign state = state_t'(state_q);
  assign illegal = bad & ~rst;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= STATE_W'(S_IF);
      opcode_reg <= '0;
    end else begin
      state_q <= STATE_W'(state_d);
      if (state == S_ID) opcode_reg <= opcode;
    end
  always_comb begin
    state_d = S_IF;
    bad = 1'b0;
    case (state)
      S_IF: state_d = ready ? S_ID : S_IF;
      S_ID:
        case (opcode)
          OP_RTYPE: state_d = S_EX_R;
          OP_LW, OP_SW: state_d = S_EX_ADDR;
          OP_BEQ: state_d = S_BEQ;
          OP_BNE: state_d = S_BNE;
          OP_J: state_d = S_JMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_EX_I;
          default: bad = 1'b1;
        endcase
      S_EX_ADDR: state_d = opcode_reg == OP_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: state_d = ready ? S_WB_LD : S_MEM_RD;
      S_MEM_WR: state_d = ready ? S_IF : S_MEM_WR;
      S_EX_R: state_d = S_WB_R;
      S_EX_I: state_d = S_WB_I;
      default: state_d = S_IF;
    endcase
  end
  multicycle_ctrl_out_dec u_dec (
    .clk_unused_n(clk),
    .state(state),
    .opcode_reg(opcode_reg),
    .ready(ready),
    .quiet(rst),
    .pc_write(pc_write),
    .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne),
    .i_or_d(i_or_d),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .ir_write(ir_write),
    .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst),
    .reg_write(reg_write),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .zero_ext(zero_ext),
    .pc_source(pc_source),
    .alu_op(alu_op),
    .i_op(i_op)
  );
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level model of the control sequence checked every cycle, plus literal cycle-count and i_op pins
module tb_multicycle_control;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, SLTI = 6'b001010, ANDI = 6'b001100, ORI = 6'b001101, XORI = 6'b001110, BAD = 6'b111111;
  typedef struct packed {
    logic pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic zero_ext;
    logic [1:0] pc_source, alu_op;
    logic [2:0] i_op;
    logic illegal;
  } ctl_t;
  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b1;
  logic [5:0] opcode = '0;
  logic pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, zero_ext, illegal;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic [2:0] i_op;
  ctl_t act;
  ctl_t exp_a[1024];
  string nm_a[1024];
  int wr = 0, rd = 0, vectors = 0, miscompares = 0, cyc = 0;
  logic [5:0] last_op = '0;
  int stamps[$];
  logic [3:0] iops[$];
  int exp_len[13] = '{4, 7, 4, 4, 3, 2, 3, 3, 5, 4, 4, 5, 5};
  logic [3:0] exp_iop[5] = '{4'b1101, 4'b0010, 4'b0000, 4'b1100, 4'b1110};
  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .zero_ext(zero_ext), .pc_source(pc_source), .alu_op(alu_op), .i_op(i_op), .illegal(illegal)
  );
  assign act = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, alu_src_b, zero_ext, pc_source, alu_op, i_op, illegal};
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (!rst && ir_write) stamps.push_back(cyc);
    if (!rst && alu_op == 2'b11) iops.push_back({zero_ext, i_op});
    if (rd < wr) begin
      vectors++;
      if (act !== exp_a[rd]) begin
        miscompares++;
        $display("FAIL %s (vector %0d): got %h want %h", nm_a[rd], rd, act, exp_a[rd]);
      end
      rd++;
    end
  end
  task automatic chk(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  task automatic step(input logic r, input logic [5:0] op, input ctl_t e, input string nm);
    mem_ready = r;
    opcode = op;
    exp_a[wr] = e;
    nm_a[wr] = nm;
    wr++;
    @(posedge clk);
    #1;
  endtask
  task automatic fetch_decode(input logic [5:0] op, input int wif);
    ctl_t e;
    for (int k = 0; k <= wif; k++) begin
      e = '0;
      e.mem_read = 1'b1;
      e.alu_src_b = 2'b01;
      e.ir_write = k == wif;
      e.pc_write = k == wif;
      e.i_op = last_op[2:0];
      step(k == wif, op, e, "IF");
    end
    e = '0;
    e.alu_src_b = 2'b11;
    e.i_op = last_op[2:0];
    e.illegal = !(op inside {R, LW, SW, BEQ, BNE, J, ADDI, SLTI, ANDI, ORI, XORI});
    step(1'b0, op, e, "ID");
    last_op = op;
  endtask
  task automatic run_instr(input logic [5:0] op, input int wif, input int wmem);
    ctl_t e, b;
    fetch_decode(op, wif);
    b = '0;
    b.i_op = op[2:0];
    if (op == R) begin
      e = b; e.alu_src_a = 1'b1; e.alu_op = 2'b10; step(1'b1, op, e, "EX_R");
      e = b; e.reg_write = 1'b1; e.reg_dst = 1'b1; step(1'b1, op, e, "WB_R");
    end else if (op inside {LW, SW}) begin
      e = b; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; step(1'b1, op, e, "EX_ADDR");
      for (int k = 0; k <= wmem; k++) begin
        e = b; e.i_or_d = 1'b1;
        if (op == LW) e.mem_read = 1'b1; else e.mem_write = 1'b1;
        step(k == wmem, op, e, op == LW ? "MEM_RD" : "MEM_WR");
      end
      if (op == LW) begin
        e = b; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; step(1'b1, op, e, "WB_LD");
      end
    end else if (op inside {BEQ, BNE}) begin
      e = b; e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_write_cond = 1'b1; e.pc_source = 2'b01; e.branch_ne = op == BNE;
      step(1'b1, op, e, "BRANCH");
    end else if (op == J) begin
      e = b; e.pc_write = 1'b1; e.pc_source = 2'b10; step(1'b1, op, e, "JMP");
    end else if (op inside {ADDI, SLTI, ANDI, ORI, XORI}) begin
      e = b; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b11; e.zero_ext = op inside {ANDI, ORI, XORI};
      step(1'b1, op, e, "EX_I");
      e = b; e.reg_write = 1'b1; step(1'b1, op, e, "WB_I");
    end
  endtask
  initial begin
    ctl_t e;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_read", int'(mem_read), 0);
    chk("reset_ir_write", int'(ir_write), 0);
    chk("reset_pc_write", int'(pc_write), 0);
    chk("reset_i_op", int'(i_op), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_instr(R, 0, 0);
    run_instr(LW, 0, 2);
    run_instr(ORI, 0, 0);
    run_instr(SLTI, 0, 0);
    run_instr(BNE, 0, 0);
    run_instr(BAD, 0, 0);
    run_instr(BEQ, 0, 0);
    run_instr(J, 0, 0);
    run_instr(SW, 0, 1);
    run_instr(ADDI, 0, 0);
    run_instr(ANDI, 0, 0);
    run_instr(XORI, 0, 0);
    run_instr(LW, 1, 0);
    fetch_decode(SW, 0);
    e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.i_op = last_op[2:0];
    step(1'b1, SW, e, "EX_ADDR");
    mem_ready = 1'b0;
    e = '0; e.i_or_d = 1'b1; e.mem_write = 1'b1; e.i_op = last_op[2:0];
    exp_a[wr] = e;
    nm_a[wr] = "MEM_WR";
    wr++;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mem_write", int'(mem_write), 0);
    chk("rst_mem_read", int'(mem_read), 0);
    chk("rst_reg_write", int'(reg_write), 0);
    chk("rst_pc_write", int'(pc_write), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    last_op = '0;
    run_instr(J, 2, 0);
    @(negedge clk);
    #1;
    chk("stamp_count_ok", int'(stamps.size() >= 14), 1);
    for (int i = 0; i < 13; i++)
      if (i + 1 < stamps.size()) chk($sformatf("instr_len_%0d", i), stamps[i + 1] - stamps[i], exp_len[i]);
    chk("iop_count", iops.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < iops.size()) chk($sformatf("zext_iop_%0d", i), int'(iops[i]), int'(exp_iop[i]));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
